// File: rtl/tachyon_schematic_gen.sv
// tachyon_schematic_gen: emits an odd-width tachyon manifold schematic, one
// character per valid/ready handshake, with splitters placed from a mask.
//
// Ports:
//   clk            - clock
//   reset          - asynchronous active-low reset
//   start          - one-cycle request to begin a schematic (accepted in IDLE only)
//   splitter_mask  - per-site splitter enables, row-major, sampled on accepted start
//   char_ready     - downstream accepts the current character
//   char_valid     - current character is valid
//   char_empty     - '.'
//   char_enter     - 'S'
//   char_splitter  - '^'
//   char_line_feed - line feed
//   busy           - high from accepted start until the final line feed transfers
//   done           - one-cycle pulse after the final line feed transfers
//   splitter_count - number of '^' emitted in the current/last schematic
module tachyon_schematic_gen #(
    parameter int unsigned TACHYON_MANIFOLD_WIDTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [((TACHYON_MANIFOLD_WIDTH-1)/2)*((TACHYON_MANIFOLD_WIDTH-1)/2+1)/2-1:0] splitter_mask,
    input  logic char_ready,
    output logic char_valid,
    output logic char_empty,
    output logic char_enter,
    output logic char_splitter,
    output logic char_line_feed,
    output logic busy,
    output logic done,
    output logic [$clog2((TACHYON_MANIFOLD_WIDTH*TACHYON_MANIFOLD_WIDTH-1)/8+1)-1:0] splitter_count
);

    localparam int unsigned W               = TACHYON_MANIFOLD_WIDTH;
    localparam int unsigned M               = (W - 1) / 2;
    localparam int unsigned NUM_SITES       = M * (M + 1) / 2;
    localparam int unsigned MAX_SPLIT_COUNT = (W * W - 1) / 8;
    localparam int unsigned NUM_LINES       = 2 * M + 1;
    localparam int unsigned LINE_W          = $clog2(NUM_LINES);
    localparam int unsigned COL_W           = $clog2(W + 1);
    localparam int unsigned SITE_W          = $clog2(NUM_SITES + 1);
    localparam int unsigned CNT_W           = $clog2(MAX_SPLIT_COUNT + 1);

    // One-hot character codes, ordered {line_feed, splitter, enter, empty}
    localparam logic [3:0] OH_EMPTY = 4'b0001;
    localparam logic [3:0] OH_ENTER = 4'b0010;
    localparam logic [3:0] OH_SPLIT = 4'b0100;
    localparam logic [3:0] OH_LF    = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [SITE_W-1:0]      site_q, site_d;
    logic [NUM_SITES-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]       count_d;
    logic [3:0]             char_d;
    logic                   valid_d, busy_d, done_d;
    logic                   xfer, last, cur_site;

    // Candidate splitter site: even line 2k (k>=1), |x-c| <= k-1 with matching parity
    function automatic logic site_at(input int line, input int col);
        int k;
        int d;
        k = line / 2;
        d = (col > int'(M)) ? col - int'(M) : int'(M) - col;
        return (line != 0) && ((line % 2) == 0) && (col < int'(W)) &&
               (d < k) && (((d + k - 1) % 2) == 0);
    endfunction

    // Character at (line, col); col == W is the line feed slot
    function automatic logic [3:0] char_at(input int line, input int col, input int site,
                                           input logic [NUM_SITES-1:0] mask);
        logic [NUM_SITES-1:0] sh;
        sh = mask >> site;
        if (col == int'(W))
            return OH_LF;
        if ((line == 0) && (col == int'(M)))
            return OH_ENTER;
        if (site_at(line, col) && sh[0])
            return OH_SPLIT;
        return OH_EMPTY;
    endfunction

    assign xfer     = char_valid && char_ready;
    assign last     = (line_q == LINE_W'(2 * M)) && (col_q == COL_W'(W));
    assign cur_site = site_at(int'(line_q), int'(col_q));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_EMIT;
            S_EMIT:  if (xfer && last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; char_* only change on start or transfer
    always_comb begin
        line_d  = line_q;
        col_d   = col_q;
        site_d  = site_q;
        mask_d  = mask_q;
        count_d = splitter_count;
        valid_d = char_valid;
        busy_d  = busy;
        done_d  = 1'b0;
        char_d  = {char_line_feed, char_splitter, char_enter, char_empty};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    line_d  = '0;
                    col_d   = '0;
                    site_d  = '0;
                    mask_d  = splitter_mask;
                    count_d = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    char_d  = char_at(0, 0, 0, splitter_mask);
                end
            end
            S_EMIT: begin
                if (xfer) begin
                    count_d = splitter_count + CNT_W'(char_splitter);
                    site_d  = site_q + SITE_W'(cur_site);
                    if (last) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        char_d  = '0;
                    end else begin
                        if (col_q == COL_W'(W)) begin
                            col_d  = '0;
                            line_d = line_q + LINE_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                        char_d = char_at(int'(line_d), int'(col_d), int'(site_d), mask_q);
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q         <= '0;
            col_q          <= '0;
            site_q         <= '0;
            mask_q         <= '0;
            splitter_count <= '0;
            char_valid     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            char_line_feed <= 1'b0;
            char_splitter  <= 1'b0;
            char_enter     <= 1'b0;
            char_empty     <= 1'b0;
        end else begin
            line_q         <= line_d;
            col_q          <= col_d;
            site_q         <= site_d;
            mask_q         <= mask_d;
            splitter_count <= count_d;
            char_valid     <= valid_d;
            busy           <= busy_d;
            done           <= done_d;
            char_line_feed <= char_d[3];
            char_splitter  <= char_d[2];
            char_enter     <= char_d[1];
            char_empty     <= char_d[0];
        end
    end

endmodule

// File: tb/tb_tachyon_schematic_gen.sv
// tb_tachyon_schematic_gen: directed bench for the schematic generator at
// W=3 and W=7; line feeds are recorded as '|' in captured frames.
module tb_tachyon_schematic_gen;

    logic clk = 1'b0;
    logic rst_n;

    logic       start3, rdy3;
    logic [0:0] mask3;
    logic       v3, e3, n3, p3, l3, b3, d3;
    logic [0:0] c3;

    logic       start7, rdy7;
    logic [5:0] mask7;
    logic       v7, e7, n7, p7, l7, b7, d7;
    logic [2:0] c7;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tachyon_schematic_gen #(.TACHYON_MANIFOLD_WIDTH(3)) dut3 (
        .clk(clk), .reset(rst_n), .start(start3), .splitter_mask(mask3),
        .char_ready(rdy3), .char_valid(v3), .char_empty(e3), .char_enter(n3),
        .char_splitter(p3), .char_line_feed(l3), .busy(b3), .done(d3),
        .splitter_count(c3)
    );

    tachyon_schematic_gen #(.TACHYON_MANIFOLD_WIDTH(7)) dut7 (
        .clk(clk), .reset(rst_n), .start(start7), .splitter_mask(mask7),
        .char_ready(rdy7), .char_valid(v7), .char_empty(e7), .char_enter(n7),
        .char_splitter(p7), .char_line_feed(l7), .busy(b7), .done(d7),
        .splitter_count(c7)
    );

    function automatic byte decode(input logic [3:0] oh);
        case (oh)
            4'b0001: return ".";
            4'b0010: return "S";
            4'b0100: return "^";
            4'b1000: return "|";
            default: return "?";
        endcase
    endfunction

    function automatic string frame7_full();
        return "...S...|.......|...^...|.......|..^.^..|.......|.^.^.^.|";
    endfunction

    function automatic string frame7_empty();
        return "...S...|.......|.......|.......|.......|.......|.......|";
    endfunction

    function automatic string frame7_sparse();
        return "...S...|.......|...^...|.......|....^..|.......|.......|";
    endfunction

    // Pulse start on the chosen instance; returns just after the accepting edge
    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 3) start3 = 1'b1; else start7 = 1'b1;
        @(posedge clk);
        #1;
        if (which == 3) start3 = 1'b0; else start7 = 1'b0;
    endtask

    // Records nexp transferred characters; counts stalled cycles whose char changed
    task automatic collect(input int which, input int nexp, input bit rnd,
                           output string s, output int unstable, output int cycles,
                           output bit to);
        int n;
        bit prev_stall;
        bit r;
        logic v;
        logic [3:0] cur, prev;
        s = "";
        unstable = 0;
        cycles = 0;
        n = 0;
        prev_stall = 1'b0;
        prev = '0;
        to = 1'b0;
        while (n < nexp) begin
            if (cycles >= nexp * 12 + 100) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
            r = rnd ? ($urandom_range(0, 99) < 40) : 1'b1;
            if (which == 3) begin
                rdy3 = r; v = v3; cur = {l3, p3, n3, e3};
            end else begin
                rdy7 = r; v = v7; cur = {l7, p7, n7, e7};
            end
            if (prev_stall && (v !== 1'b1 || cur !== prev)) unstable++;
            if (v && r) begin
                s = $sformatf("%s%c", s, decode(cur));
                n++;
            end
            prev_stall = v && !r;
            prev = cur;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start3 = 1'b0; rdy3 = 1'b1; mask3 = '0;
        start7 = 1'b0; rdy7 = 1'b1; mask7 = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({v3, e3, n3, p3, l3, b3, d3, c3} !== 8'h00) begin
            bad++; $display("FAIL reset_w3 got=%b want=0", {v3, e3, n3, p3, l3, b3, d3, c3});
        end
        total++;
        if ({v7, e7, n7, p7, l7, b7, d7, c7} !== 10'h000) begin
            bad++; $display("FAIL reset_w7 got=%b want=0", {v7, e7, n7, p7, l7, b7, d7, c7});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({v7, b7, d7} !== 3'b000) begin
            bad++; $display("FAIL idle_after_reset got=%b want=000", {v7, b7, d7});
        end
    endtask

    task automatic test_w3_basic();
        string s;
        int u, cyc;
        bit to;
        mask3 = 1'b1;
        rdy3 = 1'b1;
        pulse_start(3);
        total++;
        if ({v3, b3} !== 2'b11) begin
            bad++; $display("FAIL w3_first_valid got=%b want=11", {v3, b3});
        end
        collect(3, 12, 1'b0, s, u, cyc, to);
        total++;
        if (to) begin bad++; $display("FAIL w3_timeout got=%s", s); end
        total++;
        if (s != ".S.|...|.^.|") begin
            bad++; $display("FAIL w3_stream got=%s want=.S.|...|.^.|", s);
        end
        total++;
        if (cyc != 12) begin bad++; $display("FAIL w3_back_to_back got=%0d want=12", cyc); end
        @(negedge clk);
        total++;
        if ({d3, b3, v3} !== 3'b100) begin
            bad++; $display("FAIL w3_done_cycle got=%b want=100", {d3, b3, v3});
        end
        total++;
        if (c3 !== 1'b1) begin bad++; $display("FAIL w3_count got=%0d want=1", c3); end
        @(negedge clk);
        total++;
        if ({d3, c3} !== 2'b01) begin
            bad++; $display("FAIL w3_done_clear got=%b want=01", {d3, c3});
        end
    endtask

    task automatic test_w7_full();
        string s;
        int u, cyc;
        bit to;
        mask7 = 6'b111111;
        rdy7 = 1'b1;
        pulse_start(7);
        mask7 = 6'b000000;
        collect(7, 56, 1'b0, s, u, cyc, to);
        total++;
        if (to || s != frame7_full()) begin
            bad++; $display("FAIL w7_full_stream got=%s want=%s", s, frame7_full());
        end
        total++;
        if (cyc != 56) begin bad++; $display("FAIL w7_full_back_to_back got=%0d want=56", cyc); end
        @(negedge clk);
        total++;
        if ({d7, b7, v7} !== 3'b100) begin
            bad++; $display("FAIL w7_full_done got=%b want=100", {d7, b7, v7});
        end
        total++;
        if (c7 !== 3'd6) begin bad++; $display("FAIL w7_full_count got=%0d want=6", c7); end
    endtask

    task automatic test_w7_empty();
        string s;
        int u, cyc;
        bit to;
        mask7 = 6'b000000;
        rdy7 = 1'b1;
        pulse_start(7);
        total++;
        if (c7 !== 3'd0) begin bad++; $display("FAIL w7_count_cleared got=%0d want=0", c7); end
        collect(7, 56, 1'b0, s, u, cyc, to);
        total++;
        if (to || s != frame7_empty()) begin
            bad++; $display("FAIL w7_empty_stream got=%s want=%s", s, frame7_empty());
        end
        @(negedge clk);
        total++;
        if ({d7, c7} !== 4'b1000) begin
            bad++; $display("FAIL w7_empty_done got=%b want=1000", {d7, c7});
        end
        // start coinciding with done must be ignored
        start7 = 1'b1;
        @(posedge clk);
        #1 start7 = 1'b0;
        @(negedge clk);
        total++;
        if ({v7, b7, d7} !== 3'b000) begin
            bad++; $display("FAIL start_in_done got=%b want=000", {v7, b7, d7});
        end
    endtask

    task automatic test_start_while_busy();
        string s;
        int u, cyc;
        bit to;
        mask7 = 6'b000101;
        rdy7 = 1'b0;
        pulse_start(7);
        repeat (3) begin
            @(negedge clk);
            mask7 = 6'b111111;
            start7 = 1'b1;
        end
        @(negedge clk);
        start7 = 1'b0;
        total++;
        if ({v7, e7, b7} !== 3'b111) begin
            bad++; $display("FAIL busy_start_hold got=%b want=111", {v7, e7, b7});
        end
        collect(7, 56, 1'b0, s, u, cyc, to);
        total++;
        if (to || s != frame7_sparse()) begin
            bad++; $display("FAIL w7_sparse_stream got=%s want=%s", s, frame7_sparse());
        end
        @(negedge clk);
        total++;
        if ({d7, c7} !== 4'b1010) begin
            bad++; $display("FAIL w7_sparse_done_count got=%b want=1010", {d7, c7});
        end
    endtask

    task automatic test_backpressure();
        string s;
        int u, cyc;
        bit to;
        mask7 = 6'b111111;
        pulse_start(7);
        collect(7, 56, 1'b1, s, u, cyc, to);
        total++;
        if (to || s != frame7_full()) begin
            bad++; $display("FAIL bp_stream got=%s want=%s", s, frame7_full());
        end
        total++;
        if (u != 0) begin bad++; $display("FAIL bp_stable got=%0d unstable want=0", u); end
        rdy7 = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({b7, c7} !== 4'b0110) begin
            bad++; $display("FAIL bp_count got=%b want=0110", {b7, c7});
        end
    endtask

    task automatic test_reset_mid_frame();
        string s;
        int u, cyc;
        bit to;
        mask7 = 6'b111111;
        rdy7 = 1'b1;
        pulse_start(7);
        collect(7, 20, 1'b0, s, u, cyc, to);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({v7, b7, d7, c7} !== 6'b000000) begin
            bad++; $display("FAIL reset_mid_frame got=%b want=000000", {v7, b7, d7, c7});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(7);
        collect(7, 56, 1'b0, s, u, cyc, to);
        total++;
        if (to || s != frame7_full()) begin
            bad++; $display("FAIL after_reset_stream got=%s want=%s", s, frame7_full());
        end
        @(negedge clk);
        total++;
        if ({d7, c7} !== 4'b1110) begin
            bad++; $display("FAIL after_reset_done got=%b want=1110", {d7, c7});
        end
    endtask

    initial begin
        test_reset();
        test_w3_basic();
        test_w7_full();
        test_w7_empty();
        test_start_while_busy();
        test_backpressure();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
